bus_arbiter: RTL
================

// Module: bus_arbiter
// PURPOSE
//  Shares the single 17-bit system RAM port between two requesters: SPI commands decoded by
//  spi1 and video fetches. Round-robin grant, with a fixed ACCESS_CYCLES-long RAM cycle per
//  grant. It returns spi1's completion pulse (spi_ready) and read data, and the video ack
//  and data. It sits between spi1 / the video fetcher and the RAM pins.
// PARAMETERS
//  ACCESS_CYCLES  3  clk_sys_i cycles RAM controls are held per access; legal range 1..15
// PORTS
//  clk_sys_i      in   1   system clock; single clock domain
//  reset_i        in   1   asynchronous, active-high reset
//  spi_valid_i    in   1   level; SPI command pending (spi1 spi_valid_o)
//  spi_addr_i     in   17  SPI command address
//  spi_data_i     in   8   SPI write data
//  spi_rw_ni      in   1   SPI direction; 0 = write, 1 = read
//  spi_ready_o    out  1   1-cycle pulse; SPI command done (to spi1 spi_ready_i)
//  spi_rd_data_o  out  8   SPI read result; valid from spi_ready_o, held until next SPI read
//  video_req_i    in   1   level; video fetch pending (read only)
//  video_addr_i   in   17  video fetch address
//  video_ack_o    out  1   1-cycle pulse; video fetch done
//  video_data_o   out  8   video read result; valid from video_ack_o, held until next fetch
//  ram_addr_o     out  17  RAM address
//  ram_data_o     out  8   RAM write data
//  ram_data_i     in   8   RAM read data
//  ram_oe_o       out  1   RAM output enable (reads)
//  ram_we_o       out  1   RAM write enable (SPI writes only)
// BEHAVIOUR
//  - Reset: all outputs 0, state=IDLE, last_grant=VIDEO (SPI wins the first tie).
//    Asserting reset mid-access aborts it: no ready or ack pulse, RAM controls drop at once.
//  - All outputs are registered. FSM states are IDLE, ACCESS and DONE.
//  - IDLE: sample spi_valid_i and video_req_i.
//    - Exactly one asserted: grant it.
//    - Both asserted: grant the requester opposite last_grant.
//    - On grant, latch addr, data and rw into internal registers, update last_grant,
//      load cnt=ACCESS_CYCLES-1, and go to ACCESS.
//  - ACCESS: ram_addr_o = latched addr for the whole state.
//    - Read: ram_oe_o=1. Write: ram_we_o=1 and ram_data_o = latched data.
//    - Decrement cnt each cycle. At cnt==0, capture ram_data_i into the granted requester's
//      data register (reads only) and go to DONE.
//    - Requester inputs are ignored during ACCESS. A spi_valid_i drop (CS_N raised) does NOT
//      abort; the access completes.
//  - DONE: one cycle.
//    - ram_oe_o, ram_we_o and ram_addr_o return to 0.
//    - spi_ready_o or video_ack_o = 1 for this cycle only, per grant. Then go to IDLE.
//  - Latency: request sampled in IDLE at cycle T. RAM active T+1..T+ACCESS_CYCLES.
//    Pulse at T+ACCESS_CYCLES+1. Next grant is decided no earlier than T+ACCESS_CYCLES+2.
//  - Requester contract: spi1 drops spi_valid_i the cycle after spi_ready_o. The video
//    fetcher drops video_req_i the cycle after video_ack_o. A request still high in IDLE
//    counts as a new request.
//  - ram_we_o and ram_oe_o are never both 1. Video grants never assert ram_we_o.
//  - Non-granted data outputs keep their values. SPI writes leave spi_rd_data_o unchanged.
//  - cnt is 4 bits, with no wrap: ACCESS_CYCLES=1 means exactly one ACCESS cycle.
// TESTING
//  - Reset: assert reset_i during ACCESS of an SPI read -> all outputs 0 immediately, no
//    spi_ready_o; after release the FSM is in IDLE.
//  - SPI write, addr=17'h08000, data=8'hA5, ACCESS_CYCLES=3 -> ram_we_o=1 with that
//    addr/data for exactly 3 cycles, ram_oe_o=0, then a 1-cycle spi_ready_o.
//  - SPI read, addr=17'h1FFFF, ram_data_i=8'h3C -> spi_rd_data_o=8'h3C on the spi_ready_o
//    cycle and held afterwards; video_data_o unchanged.
//  - Both requests asserted in the same cycle, held continuously -> grant order SPI, VIDEO,
//    SPI, VIDEO; never two consecutive grants to one requester while both are pending.
//  - spi_valid_i dropped mid-ACCESS -> access still runs the full 3 cycles and the
//    spi_ready_o pulse still fires; no second grant afterwards.
//  - ACCESS_CYCLES=1, video fetch addr=17'h00400 -> ram_oe_o high for exactly 1 cycle,
//    video_ack_o 2 cycles after the request is sampled.

Source files
------------

// File: rtl/bus_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : bus_arbiter
// Description : Round-robin arbiter sharing the single 17-bit system RAM port
//               between SPI commands (decoded by spi1) and video fetches.
//               Each grant runs a fixed ACCESS_CYCLES-long RAM cycle, followed
//               by a one-cycle completion pulse to the granted requester.
//
// Parameters  : ACCESS_CYCLES  clk_sys_i cycles RAM controls are held per
//                              access (legal range 1..15)
//
// Ports       : clk_sys_i      system clock, single domain
//               reset_i        asynchronous active-high reset
//               spi_valid_i    SPI command pending (level)
//               spi_addr_i     SPI command address
//               spi_data_i     SPI write data
//               spi_rw_ni      SPI direction, 0 = write, 1 = read
//               spi_ready_o    1-cycle pulse, SPI command done
//               spi_rd_data_o  SPI read result, held until next SPI read
//               video_req_i    video fetch pending (level, read only)
//               video_addr_i   video fetch address
//               video_ack_o    1-cycle pulse, video fetch done
//               video_data_o   video read result, held until next fetch
//               ram_addr_o     RAM address
//               ram_data_o     RAM write data
//               ram_data_i     RAM read data
//               ram_oe_o       RAM output enable (reads)
//               ram_we_o       RAM write enable (SPI writes only)
//
// Revision    : 1.0  initial release
// ============================================================================
module bus_arbiter #(
    parameter int ACCESS_CYCLES = 3
) (
    input  logic        clk_sys_i,
    input  logic        reset_i,
    input  logic        spi_valid_i,
    input  logic [16:0] spi_addr_i,
    input  logic [7:0]  spi_data_i,
    input  logic        spi_rw_ni,
    output logic        spi_ready_o,
    output logic [7:0]  spi_rd_data_o,
    input  logic        video_req_i,
    input  logic [16:0] video_addr_i,
    output logic        video_ack_o,
    output logic [7:0]  video_data_o,
    output logic [16:0] ram_addr_o,
    output logic [7:0]  ram_data_o,
    input  logic [7:0]  ram_data_i,
    output logic        ram_oe_o,
    output logic        ram_we_o
);

    localparam logic [1:0] c_st_idle   = 2'd0;
    localparam logic [1:0] c_st_access = 2'd1;
    localparam logic [1:0] c_st_done   = 2'd2;

    // Requester identifiers used for the grant and last-grant registers.
    localparam logic c_sel_spi   = 1'b0;
    localparam logic c_sel_video = 1'b1;

    // The down-counter starts at ACCESS_CYCLES-1 and the access ends on the
    // cycle it reads zero, so the RAM sees exactly ACCESS_CYCLES cycles.
    localparam logic [3:0] c_cnt_load = 4'(ACCESS_CYCLES - 1);

    logic [1:0] r_state;
    logic [3:0] r_cnt;
    logic       r_last_grant;
    logic       r_grant;
    logic       r_read;

    logic       w_grant_spi;
    logic       w_grant_video;
    logic       w_grant_read;
    logic [16:0] w_grant_addr;

    // Round-robin decision: a lone request always wins; on a tie the
    // requester that was not served last goes first.
    always_comb begin
        w_grant_spi   = 1'b0;
        w_grant_video = 1'b0;
        if (spi_valid_i && video_req_i) begin
            if (r_last_grant == c_sel_video) begin
                w_grant_spi = 1'b1;
            end else begin
                w_grant_video = 1'b1;
            end
        end else begin
            w_grant_spi   = spi_valid_i;
            w_grant_video = video_req_i;
        end
    end

    assign w_grant_read = w_grant_video ? 1'b1 : spi_rw_ni;
    assign w_grant_addr = w_grant_video ? video_addr_i : spi_addr_i;

    // The registered RAM address / write-data outputs double as the latched
    // copies of the granted request; they are loaded on grant and held for
    // the whole ACCESS state while the requester inputs are ignored.
    always_ff @(posedge clk_sys_i or posedge reset_i) begin
        if (reset_i) begin
            r_state       <= c_st_idle;
            r_cnt         <= 4'd0;
            r_last_grant  <= c_sel_video;
            r_grant       <= c_sel_spi;
            r_read        <= 1'b0;
            spi_ready_o   <= 1'b0;
            spi_rd_data_o <= 8'd0;
            video_ack_o   <= 1'b0;
            video_data_o  <= 8'd0;
            ram_addr_o    <= 17'd0;
            ram_data_o    <= 8'd0;
            ram_oe_o      <= 1'b0;
            ram_we_o      <= 1'b0;
        end else begin
            // Completion pulses last a single cycle.
            spi_ready_o <= 1'b0;
            video_ack_o <= 1'b0;

            case (r_state)
                c_st_idle: begin
                    if (w_grant_spi || w_grant_video) begin
                        r_grant      <= w_grant_video ? c_sel_video : c_sel_spi;
                        r_last_grant <= w_grant_video ? c_sel_video : c_sel_spi;
                        r_read       <= w_grant_read;
                        r_cnt        <= c_cnt_load;
                        ram_addr_o   <= w_grant_addr;
                        ram_oe_o     <= w_grant_read;
                        ram_we_o     <= ~w_grant_read;
                        ram_data_o   <= w_grant_read ? 8'd0 : spi_data_i;
                        r_state      <= c_st_access;
                    end
                end

                c_st_access: begin
                    if (r_cnt == 4'd0) begin
                        if (r_read) begin
                            if (r_grant == c_sel_video) begin
                                video_data_o <= ram_data_i;
                            end else begin
                                spi_rd_data_o <= ram_data_i;
                            end
                        end
                        if (r_grant == c_sel_video) begin
                            video_ack_o <= 1'b1;
                        end else begin
                            spi_ready_o <= 1'b1;
                        end
                        ram_addr_o <= 17'd0;
                        ram_data_o <= 8'd0;
                        ram_oe_o   <= 1'b0;
                        ram_we_o   <= 1'b0;
                        r_state    <= c_st_done;
                    end else begin
                        r_cnt <= r_cnt - 4'd1;
                    end
                end

                c_st_done: begin
                    r_state <= c_st_idle;
                end

                default: begin
                    r_state <= c_st_idle;
                end
            endcase
        end
    end

endmodule
`default_nettype wire
